// File: rtl/anc_pkg.sv
// rtl/anc_pkg.sv - shared state enum and default widths for the ANC phase scheduler
package anc_pkg;

  localparam int PHASE_W = 24;
  localparam int COUNT_W = 24;
  localparam int TONE_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } anc_state_e;

endpackage

// File: rtl/anc_phase_sched.sv
// rtl/anc_phase_sched.sv - tone-sweep scheduler producing AXI-stream phase words
module anc_phase_sched
  import anc_pkg::*;
#(
  parameter int PHASE_WIDTH = PHASE_W,
  parameter int COUNT_WIDTH = COUNT_W,
  parameter int TONE_WIDTH  = TONE_W
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic [PHASE_WIDTH-1:0] cfg_start_ph,
  input  logic [PHASE_WIDTH-1:0] cfg_dph_inc,
  input  logic [PHASE_WIDTH-1:0] cfg_dph_step,
  input  logic [COUNT_WIDTH-1:0] cfg_nsig,
  input  logic [TONE_WIDTH-1:0]  cfg_ntones,
  input  logic                   cfg_loop,
  output logic [PHASE_WIDTH-1:0] phase_tdata,
  output logic                   phase_tvalid,
  output logic                   phase_tlast,
  input  logic                   phase_tready,
  output logic [TONE_WIDTH-1:0]  tone_idx,
  output logic                   busy,
  output logic                   done
);

  anc_state_e             state_q, state_d;
  logic [PHASE_WIDTH-1:0] phase_q, phase_d;
  logic [PHASE_WIDTH-1:0] dph_q, dph_d;
  logic [COUNT_WIDTH-1:0] ncount_q, ncount_d;
  logic [TONE_WIDTH-1:0]  tone_q, tone_d;
  logic [PHASE_WIDTH-1:0] start_ph_q, start_ph_d;
  logic [PHASE_WIDTH-1:0] dph_inc_q, dph_inc_d;
  logic [PHASE_WIDTH-1:0] dph_step_q, dph_step_d;
  logic [COUNT_WIDTH-1:0] nsig_q, nsig_d;
  logic [TONE_WIDTH-1:0]  ntones_q, ntones_d;
  logic                   loop_q, loop_d;

  logic last_sample;
  logic last_tone;

  assign last_sample = (ncount_q == nsig_q);
  assign last_tone   = (tone_q == ntones_q - TONE_WIDTH'(1));

  assign phase_tdata  = phase_q;
  assign phase_tvalid = (state_q == ST_RUN);
  assign phase_tlast  = (state_q == ST_RUN) && last_sample;
  assign tone_idx     = tone_q;
  assign busy         = (state_q == ST_RUN);
  assign done         = (state_q == ST_DONE);

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    dph_d      = dph_q;
    ncount_d   = ncount_q;
    tone_d     = tone_q;
    start_ph_d = start_ph_q;
    dph_inc_d  = dph_inc_q;
    dph_step_d = dph_step_q;
    nsig_d     = nsig_q;
    ntones_d   = ntones_q;
    loop_d     = loop_q;

    // Abort is a flush: the beat in flight is dropped, no done pulse.
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            start_ph_d = cfg_start_ph;
            dph_inc_d  = cfg_dph_inc;
            dph_step_d = cfg_dph_step;
            nsig_d     = (cfg_nsig == '0) ? COUNT_WIDTH'(1) : cfg_nsig;
            ntones_d   = (cfg_ntones == '0) ? TONE_WIDTH'(1) : cfg_ntones;
            loop_d     = cfg_loop;
            phase_d    = cfg_start_ph;
            dph_d      = cfg_dph_inc;
            ncount_d   = COUNT_WIDTH'(1);
            tone_d     = '0;
            state_d    = ST_RUN;
          end
        end
        ST_RUN: begin
          if (phase_tready) begin
            if (!last_sample) begin
              phase_d  = phase_q + dph_q;
              ncount_d = ncount_q + COUNT_WIDTH'(1);
            end else if (!last_tone) begin
              tone_d   = tone_q + TONE_WIDTH'(1);
              dph_d    = dph_q + dph_step_q;
              phase_d  = start_ph_q;
              ncount_d = COUNT_WIDTH'(1);
            end else if (loop_q) begin
              tone_d   = '0;
              dph_d    = dph_inc_q;
              phase_d  = start_ph_q;
              ncount_d = COUNT_WIDTH'(1);
            end else begin
              state_d = ST_DONE;
            end
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      phase_q    <= '0;
      dph_q      <= '0;
      ncount_q   <= '0;
      tone_q     <= '0;
      start_ph_q <= '0;
      dph_inc_q  <= '0;
      dph_step_q <= '0;
      nsig_q     <= '0;
      ntones_q   <= '0;
      loop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      dph_q      <= dph_d;
      ncount_q   <= ncount_d;
      tone_q     <= tone_d;
      start_ph_q <= start_ph_d;
      dph_inc_q  <= dph_inc_d;
      dph_step_q <= dph_step_d;
      nsig_q     <= nsig_d;
      ntones_q   <= ntones_d;
      loop_q     <= loop_d;
    end
  end

endmodule

// File: tb/tb_anc_phase_sched.sv
// tb/tb_anc_phase_sched.sv - scoreboard bench for anc_phase_sched
module tb_anc_phase_sched;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [23:0] cfg_start_ph = '0;
  logic [23:0] cfg_dph_inc = '0;
  logic [23:0] cfg_dph_step = '0;
  logic [23:0] cfg_nsig = '0;
  logic [7:0]  cfg_ntones = '0;
  logic        cfg_loop = 1'b0;
  logic [23:0] phase_tdata;
  logic        phase_tvalid;
  logic        phase_tlast;
  logic        phase_tready = 1'b1;
  logic [7:0]  tone_idx;
  logic        busy;
  logic        done;

  typedef struct packed {
    logic [23:0] d;
    logic        l;
    logic [7:0]  t;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;
  bit   mon_en = 1'b1;

  anc_phase_sched dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .abort        (abort),
    .cfg_start_ph (cfg_start_ph),
    .cfg_dph_inc  (cfg_dph_inc),
    .cfg_dph_step (cfg_dph_step),
    .cfg_nsig     (cfg_nsig),
    .cfg_ntones   (cfg_ntones),
    .cfg_loop     (cfg_loop),
    .phase_tdata  (phase_tdata),
    .phase_tvalid (phase_tvalid),
    .phase_tlast  (phase_tlast),
    .phase_tready (phase_tready),
    .tone_idx     (tone_idx),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (mon_en && phase_tvalid === 1'b1 && phase_tready === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        assert (q.size() != 0) else begin
          errors++;
          $error("FAIL unexpected_word observed=%h expected=none", phase_tdata);
        end
      end else begin
        exp_t e;
        e = q.pop_front();
        check("tdata", {8'h0, phase_tdata}, {8'h0, e.d});
        check("tlast", {31'h0, phase_tlast}, {31'h0, e.l});
        check("tone_idx", {24'h0, tone_idx}, {24'h0, e.t});
      end
    end
  end

  task automatic push_sweep(input logic [23:0] sp, input logic [23:0] inc, input logic [23:0] step,
                            input int ns, input int nt, input int reps);
    logic [23:0] ph;
    logic [23:0] dph;
    exp_t        e;
    for (int r = 0; r < reps; r++) begin
      dph = inc;
      for (int t = 0; t < nt; t++) begin
        ph = sp;
        for (int s = 0; s < ns; s++) begin
          e.d = ph;
          e.l = (s == ns - 1);
          e.t = 8'(t);
          q.push_back(e);
          ph = ph + dph;
        end
        dph = dph + step;
      end
    end
  endtask

  task automatic start_sweep(input logic [23:0] sp, input logic [23:0] inc, input logic [23:0] step,
                             input logic [23:0] ns, input logic [7:0] nt, input logic lp);
    cfg_start_ph = sp;
    cfg_dph_inc  = inc;
    cfg_dph_step = step;
    cfg_nsig     = ns;
    cfg_ntones   = nt;
    cfg_loop     = lp;
    start = 1'b1;
    tick();
    start = 1'b0;
    // Scramble the config so any late sampling shows up in the data.
    cfg_start_ph = 24'($urandom);
    cfg_dph_inc  = 24'($urandom);
    cfg_dph_step = 24'($urandom);
    cfg_nsig     = 24'($urandom_range(1, 9));
    cfg_ntones   = 8'($urandom_range(1, 9));
    cfg_loop     = 1'($urandom);
  endtask

  task automatic wait_empty(input string tag, input int limit);
    int n = 0;
    while (q.size() != 0 && n < limit) begin
      tick();
      n++;
    end
    check(tag, q.size(), 0);
  endtask

  task automatic wait_done(input string tag, input int limit);
    int n = 0;
    while (done !== 1'b1 && n < limit) begin
      tick();
      n++;
    end
    check(tag, {31'h0, done}, 32'h1);
  endtask

  initial begin
    int          n;
    int          dc;
    logic [3:0]  pat;
    logic [24:0] prev;
    logic        stalled;

    #1000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int          n;
    int          dc;
    logic [3:0]  pat;
    logic [24:0] prev;
    logic        stalled;

    // Reset state
    tick();
    tick();
    check("rst_tdata", {8'h0, phase_tdata}, 32'h0);
    check("rst_tvalid", {31'h0, phase_tvalid}, 32'h0);
    check("rst_tlast", {31'h0, phase_tlast}, 32'h0);
    check("rst_tone", {24'h0, tone_idx}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_done", {31'h0, done}, 32'h0);
    reset_n = 1'b1;
    tick();

    // Basic single-tone sweep with exact done timing
    push_sweep(24'd0, 24'd2048, 24'd0, 4, 1, 1);
    start_sweep(24'd0, 24'd2048, 24'd0, 24'd4, 8'd1, 1'b0);
    check("t1_busy", {31'h0, busy}, 32'h1);
    for (int i = 0; i < 4; i++) tick();
    check("t1_empty", q.size(), 0);
    check("t1_done", {31'h0, done}, 32'h1);
    check("t1_busy_done", {31'h0, busy}, 32'h0);
    tick();
    check("t1_done_low", {31'h0, done}, 32'h0);
    check("t1_idle_busy", {31'h0, busy}, 32'h0);
    check("t1_idle_tvalid", {31'h0, phase_tvalid}, 32'h0);

    // Three tones with stepped increment
    push_sweep(24'd10, 24'd100, 24'd50, 3, 3, 1);
    start_sweep(24'd10, 24'd100, 24'd50, 24'd3, 8'd3, 1'b0);
    wait_empty("t2_empty", 40);
    wait_done("t2_done", 10);
    tick();

    // Backpressure pattern 1,0,0,1 repeating
    pat = 4'b1001;
    push_sweep(24'd0, 24'd2048, 24'd0, 4, 1, 1);
    start_sweep(24'd0, 24'd2048, 24'd0, 24'd4, 8'd1, 1'b0);
    n = 0;
    while (busy === 1'b1 && n < 50) begin
      phase_tready = pat[n % 4];
      stalled = ~phase_tready;
      prev = {phase_tdata, phase_tlast};
      tick();
      n++;
      if (stalled) check("t3_hold", {7'h0, phase_tdata, phase_tlast}, {7'h0, prev});
    end
    phase_tready = 1'b1;
    check("t3_cycles", n, 8);
    check("t3_done", {31'h0, done}, 32'h1);
    check("t3_empty", q.size(), 0);
    tick();

    // Looping sweep, then abort mid-tone
    dc = done_cnt;
    push_sweep(24'd0, 24'd1, 24'd1, 2, 2, 2);
    start_sweep(24'd0, 24'd1, 24'd1, 24'd2, 8'd2, 1'b1);
    wait_empty("t4_empty", 30);
    phase_tready = 1'b0;
    tick();
    check("t4_wrap_tdata", {8'h0, phase_tdata}, 32'h0);
    check("t4_wrap_tone", {24'h0, tone_idx}, 32'h0);
    check("t4_busy", {31'h0, busy}, 32'h1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    phase_tready = 1'b1;
    check("t4_abort_tvalid", {31'h0, phase_tvalid}, 32'h0);
    check("t4_abort_busy", {31'h0, busy}, 32'h0);
    tick();
    check("t4_no_done", done_cnt, dc);

    // Zero nsig/ntones substitution
    push_sweep(24'h123456, 24'd5, 24'd7, 1, 1, 1);
    start_sweep(24'h123456, 24'd5, 24'd7, 24'd0, 8'd0, 1'b0);
    wait_empty("t5_empty", 10);
    wait_done("t5_done", 5);
    tick();

    // Phase wrap modulo 2^24
    push_sweep(24'hFFFFFF, 24'd2, 24'd0, 2, 1, 1);
    start_sweep(24'hFFFFFF, 24'd2, 24'd0, 24'd2, 8'd1, 1'b0);
    wait_empty("t6_empty", 10);
    wait_done("t6_done", 5);
    tick();

    // Asynchronous reset mid-run
    mon_en = 1'b0;
    start_sweep(24'd77, 24'd3, 24'd0, 24'd8, 8'd2, 1'b0);
    tick();
    tick();
    #3;
    reset_n = 1'b0;
    #1;
    check("ar_tdata", {8'h0, phase_tdata}, 32'h0);
    check("ar_tvalid", {31'h0, phase_tvalid}, 32'h0);
    check("ar_tlast", {31'h0, phase_tlast}, 32'h0);
    check("ar_tone", {24'h0, tone_idx}, 32'h0);
    check("ar_busy", {31'h0, busy}, 32'h0);
    check("ar_done", {31'h0, done}, 32'h0);
    tick();
    reset_n = 1'b1;
    tick();
    mon_en = 1'b1;

    // Start during RUN is ignored
    push_sweep(24'd5, 24'd7, 24'd0, 3, 1, 1);
    start_sweep(24'd5, 24'd7, 24'd0, 24'd3, 8'd1, 1'b0);
    cfg_start_ph = 24'd999;
    cfg_nsig     = 24'd6;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_empty("t7_empty", 10);
    wait_done("t7_done", 5);
    tick();
    tick();
    check("t7_idle", {31'h0, busy}, 32'h0);

    // Start and abort together: abort wins
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("sa_tvalid", {31'h0, phase_tvalid}, 32'h0);
    check("sa_busy", {31'h0, busy}, 32'h0);
    tick();
    check("sa_busy2", {31'h0, busy}, 32'h0);
    check("sa_done", {31'h0, done}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
